// File: rtl/md_sched.sv
// Multiply/divide scheduler: holds HI/LO-class ops busy for a fixed latency,
// then commits a precomputed 64-bit result to the HI/LO registers.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CW = 4;
  localparam int unsigned DW = 32;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic            state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*DW-1:0] pend_q, pend_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;

  logic [2*DW-1:0] a_sx, b_sx, prod_s, prod_u, acc;
  logic [DW-1:0]   abs_a, abs_b, qmag, rmag, sdiv_q, sdiv_r, udiv_q, udiv_r;
  logic [2*DW-1:0] arith_res;
  logic            is_arith;
  logic [CW-1:0]   op_lat;

  // Datapath: products and divides computed from the start-cycle operands and HI/LO
  always_comb begin
    a_sx   = {{DW{rs_data[DW-1]}}, rs_data};
    b_sx   = {{DW{rt_data[DW-1]}}, rt_data};
    prod_s = a_sx * b_sx;
    prod_u = {DW'(0), rs_data} * {DW'(0), rt_data};
    acc    = {hi_q, lo_q};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000
    abs_a  = rs_data[DW-1] ? (DW'(0) - rs_data) : rs_data;
    abs_b  = rt_data[DW-1] ? (DW'(0) - rt_data) : rt_data;
    qmag   = (abs_b != DW'(0)) ? (abs_a / abs_b) : DW'(0);
    rmag   = (abs_b != DW'(0)) ? (abs_a % abs_b) : DW'(0);
    sdiv_q = (rs_data[DW-1] ^ rt_data[DW-1]) ? (DW'(0) - qmag) : qmag;
    sdiv_r = rs_data[DW-1] ? (DW'(0) - rmag) : rmag;
    udiv_q = (rt_data != DW'(0)) ? (rs_data / rt_data) : DW'(0);
    udiv_r = (rt_data != DW'(0)) ? (rs_data % rt_data) : DW'(0);

    arith_res = acc;
    is_arith  = 1'b0;
    op_lat    = CW'(MULT_CYCLES);
    case (mdop)
      OP_MULT:  begin is_arith = 1'b1; arith_res = prod_s; end
      OP_MULTU: begin is_arith = 1'b1; arith_res = prod_u; end
      OP_MADD:  begin is_arith = 1'b1; arith_res = acc + prod_s; end
      OP_MSUB:  begin is_arith = 1'b1; arith_res = acc - prod_s; end
      OP_DIV: begin
        is_arith = 1'b1;
        op_lat   = CW'(DIV_CYCLES);
        // Divide by zero commits the unchanged HI/LO
        if (rt_data != DW'(0)) arith_res = {sdiv_r, sdiv_q};
      end
      OP_DIVU: begin
        is_arith = 1'b1;
        op_lat   = CW'(DIV_CYCLES);
        if (rt_data != DW'(0)) arith_res = {udiv_r, udiv_q};
      end
      default: ;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_arith) begin
            pend_d  = arith_res;
            cnt_d   = op_lat;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else if (mdop == OP_MTHI) begin
            hi_d = rs_data;
          end else if (mdop == OP_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          {hi_d, lo_d} = pend_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched with hand-computed HI/LO results.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdop;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdop    (mdop),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Single-cycle write/no-op request; called just after a falling edge
  task automatic do_wr(input logic [3:0] op, input logic [31:0] val);
    start = 1'b1; mdop = op; rs_data = val; rt_data = 32'h0;
    @(negedge clk);
    start = 1'b0; mdop = 4'd0;
  endtask

  // Issue an arithmetic op, count busy cycles, optionally pulse mtlo mid-window;
  // returns in the cycle where done should be high
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input bit inj, input string tag);
    int cnt;
    start = 1'b1; mdop = op; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; mdop = 4'd0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      check({tag, "_nodone"}, 64'(done), 64'd0);
      if (inj && cnt == 2) begin
        start = 1'b1; mdop = 4'd8; rs_data = 32'hDEAD;
      end else begin
        start = 1'b0; mdop = 4'd0;
      end
      @(negedge clk);
    end
    start = 1'b0; mdop = 4'd0;
    check({tag, "_cycles"}, 64'(cnt), 64'(n));
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic step_done_low(input string tag);
    @(negedge clk);
    check({tag, "_done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; mdop = 4'd0; rs_data = '0; rt_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 5, 1'b0, "mult");
    check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    step_done_low("mult");

    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b0, "div");
    check("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    step_done_low("div");

    run_op(4'd4, 32'hFFFFFFF9, 32'd2, 10, 1'b0, "divu");
    check("divu_hilo", {hi, lo}, 64'h00000001_7FFFFFFC);
    step_done_low("divu");

    do_wr(4'd7, 32'd0);
    do_wr(4'd8, 32'd10);
    check("mt_hilo", {hi, lo}, 64'h00000000_0000000A);
    check("mt_busy", 64'(busy), 64'd0);
    run_op(4'd5, 32'd3, 32'd4, 5, 1'b1, "madd");
    check("madd_hilo", {hi, lo}, 64'h00000000_00000016);
    step_done_low("madd");
    run_op(4'd6, 32'd5, 32'd5, 5, 1'b1, "msub");
    check("msub_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    step_done_low("msub");

    do_wr(4'd7, 32'h11);
    do_wr(4'd8, 32'h22);
    run_op(4'd3, 32'd5, 32'd0, 10, 1'b0, "div0");
    check("div0_hilo", {hi, lo}, 64'h00000011_00000022);
    step_done_low("div0");

    do_wr(4'd9, 32'hCAFE);
    check("noop_busy", 64'(busy), 64'd0);
    check("noop_hilo", {hi, lo}, 64'h00000011_00000022);

    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, "divovf");
    check("divovf_hilo", {hi, lo}, 64'h00000000_80000000);
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0, "b2b_multu");
    check("b2b_multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    step_done_low("b2b_multu");

    // Abort a mult in its third busy cycle
    start = 1'b1; mdop = 4'd1; rs_data = 32'd7; rt_data = 32'd9;
    @(negedge clk);
    start = 1'b0; mdop = 4'd0;
    check("rmid_busy1", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rmid_busy", 64'(busy), 64'd0);
    check("rmid_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("rmid_no_done", 64'(pulses), 64'd0);
    check("rmid_hilo_after", {hi, lo}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the pipelined CPU's execute stage. It accepts one HI/LO-class operation per start pulse: mult, multu, div, divu, madd, msub, mthi and mtlo. Arithmetic ops are held busy for a fixed multi-cycle latency before committing to the HI/LO registers. The pipeline uses `busy` to stall any later HI/LO-class instruction, while the single-cycle integer ALU keeps running independently.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult, multu, madd and msub (legal range 1..15).
- `DIV_CYCLES`, default 10: busy cycles for div and divu (legal range 1..15).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle request, qualified by `mdop`.
- `mdop`  in  4  op encoding: 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 msub, 7 mthi, 8 mtlo; every other value is a no-op.
- `rs_data`  in  32  operand A, or the write data for mthi/mtlo.
- `rt_data`  in  32  operand B.
- `busy`  out  1  an arithmetic op is in flight.
- `done`  out  1  one-cycle pulse after an arithmetic commit.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE and RUN; reset enters IDLE.
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, pending result=0.
- IDLE + `start` + arithmetic op:
  - Capture the full 64-bit result into the pending register, computed from `rs_data`/`rt_data` and the current `hi`/`lo`.
  - Load the counter with the op's latency and go to RUN.
- IDLE + `start` + mthi/mtlo: write `rs_data` to `hi`/`lo` at that edge; remain in IDLE; `busy` stays 0; no `done`.
- IDLE + `start` + undefined `mdop`: no state change.
- RUN: decrement the counter every cycle.
  - At the edge where counter==1, write the pending result to `{hi,lo}`, clear `busy`, set `done`, and return to IDLE.
- Any `start` while in RUN is ignored entirely, including mthi/mtlo. The pipeline must stall; the block does not queue requests.
- Arithmetic rules:
  - mult: `{hi,lo}` = signed A×B, 64-bit.
  - multu: `{hi,lo}` = unsigned A×B.
  - madd: `{hi,lo}` = `{hi,lo}` + signed A×B, mod 2^64.
  - msub: `{hi,lo}` = `{hi,lo}` − signed A×B, mod 2^64.
  - div: `lo` = quotient truncated toward zero; `hi` = remainder carrying the dividend's sign.
  - div with 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
  - divu: unsigned quotient/remainder.
  - div or divu with B=0: the op still occupies `DIV_CYCLES` busy cycles; `hi`/`lo` remain unchanged at commit.
- `hi`/`lo` only change on an mthi/mtlo edge or a commit edge; they are never partially updated.

## Timing
- Start sampled at edge 0 with an arithmetic op: `busy`=1 from after edge 0 through edge N−1, where N is the op latency.
  - At edge N: commit, `busy`=0, `done`=1.
  - After edge N+1: `done`=0.
- `busy` is therefore high for exactly N cycles.
- A new `start` is accepted in the same cycle that `done` is high. Back-to-back ops lose no cycle.
- mthi/mtlo take effect at the sampling edge; the new value is visible on `hi`/`lo` the following cycle.
- madd/msub use the `hi`/`lo` value present in the start cycle. This includes a value committed at that same edge's predecessor, so back-to-back madd chains accumulate correctly.
- Reset asserted mid-RUN aborts the op: `busy`, `done`, `hi` and `lo` go to 0 immediately (asynchronously), and the pending result is discarded.
- `busy` and `done` are registered outputs with no combinational path from `start`.

## Test plan
- Signed multiply: mult A=0xFFFFFFFE (−2), B=3 → `busy` high 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, with a single `done` pulse.
- Signed and unsigned divide:
  - div A=−7 (0xFFFFFFF9), B=2 → after 10 busy cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - divu of the same operands → `lo`=0x7FFFFFFC, `hi`=1.
- Accumulate and the busy lockout:
  - mthi 0 and mtlo 10, then madd A=3, B=4 → `lo`=22, `hi`=0.
  - Then msub A=5, B=5 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - An mtlo pulsed during either busy window is ignored.
- Division by zero: with `hi`=0x11, `lo`=0x22, div A=5, B=0 → `busy` high 10 cycles, `done` pulses, `hi`/`lo` still 0x11/0x22.
- Overflow and back-to-back: div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0. A multu 0xFFFFFFFF×0xFFFFFFFF started in the `done` cycle → `hi`=0xFFFFFFFE, `lo`=1 exactly 5 cycles later.
- Reset mid-op: assert `reset` in the 3rd busy cycle of a mult → `busy`, `hi` and `lo` read 0 immediately, and no `done` pulse follows after release.
